// File: rtl/uart_cmd_decoder.sv
// UART 8N1 receiver and line-command parser: S/H/C pulses, L<ddd> threshold, T<hhmm> BCD time set.
// Optional inter-byte timeout: define CMD_TIMEOUT_EN.
module uart_cmd_decoder #(
    parameter int BAUD_COUNT_x16 = 651,
    parameter int BAUD_BIT_x16   = 10,
    parameter int OVER_SAMPL     = 16,
    parameter int LIV_DEFAULT    = 100,
    parameter int TIMEOUT_TICKS  = 3200,
    parameter int TIMEOUT_BIT    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_ready,
    output logic       o_status,
    output logic       o_history,
    output logic       o_change,
    output logic [8:0] o_livello,
    output logic       o_lev_valid,
    output logic [3:0] o_dore,
    output logic [3:0] o_ore,
    output logic [3:0] o_dmin,
    output logic [3:0] o_min,
    output logic       o_time_valid,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam int SW = $clog2(OVER_SAMPL);
    localparam logic [SW-1:0] SAMP_HALF = SW'(OVER_SAMPL / 2 - 1);
    localparam logic [SW-1:0] SAMP_FULL = SW'(OVER_SAMPL - 1);
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    if (BAUD_COUNT_x16 > (1 << BAUD_BIT_x16)) begin : g_bad_baud_width
        $error("BAUD_BIT_x16 too narrow for BAUD_COUNT_x16");
    end
    if (TIMEOUT_TICKS > (1 << TIMEOUT_BIT)) begin : g_bad_timeout_width
        $error("TIMEOUT_BIT too narrow for TIMEOUT_TICKS");
    end

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} r_state_e;
    typedef enum logic [1:0] {P_IDLE, P_ARGS, P_CR, P_FLUSH} p_state_e;

    // ---------------- input synchroniser and tick generator ----------------
    logic rx_meta, rx_sync, rx_prev;
    logic [BAUD_BIT_x16-1:0] baud_cnt;
    logic tick, start_edge;

    // NOTE: sequential state is always assigned with <=, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick = (baud_cnt == BAUD_BIT_x16'(BAUD_COUNT_x16 - 1));

    always_ff @(posedge clk) begin
        if (!rst || start_edge || tick) baud_cnt <= '0;
        else                            baud_cnt <= baud_cnt + 1'b1;
    end

    // ---------------- receiver ----------------
    r_state_e r_state, r_next;
    logic [SW-1:0] samp_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic bit_end, frame_ok, frame_bad;

    assign bit_end = tick && (samp_cnt == SAMP_FULL);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        r_next     = r_state;
        start_edge = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (r_state)
            R_IDLE: if (rx_prev && !rx_sync) begin
                start_edge = 1'b1;
                r_next     = R_START;
            end
            R_START: if (tick && samp_cnt == SAMP_HALF) r_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (bit_end && bit_idx == 3'd7) r_next = R_STOP;
            R_STOP: if (bit_end) begin
                frame_ok  = rx_sync;
                frame_bad = !rx_sync;
                r_next    = rx_sync ? R_IDLE : R_WAITHI;
            end
            R_WAITHI: if (rx_sync) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            samp_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            o_rx_byte  <= '0;
            o_rx_ready <= 1'b0;
        end else begin
            // Counter restarts on every state change, so each phase counts from its own entry.
            if (r_next != r_state) samp_cnt <= '0;
            else if (tick)         samp_cnt <= samp_cnt + 1'b1;
            if (r_state != R_DATA) bit_idx <= '0;
            else if (bit_end)      bit_idx <= bit_idx + 1'b1;
            if (r_state == R_DATA && bit_end) shift_reg <= {rx_sync, shift_reg[7:1]};
            if (frame_ok) o_rx_byte <= shift_reg;
            o_rx_ready <= frame_ok;
        end
    end

    // ---------------- parser ----------------
    p_state_e p_state, p_next;
    logic [7:0]  cmd;
    logic [2:0]  dig_cnt, need;
    logic [9:0]  acc;
    logic [15:0] bcd;
    logic is_digit, is_cr, time_ok, to_hit;
    logic ex_status, ex_history, ex_change, lev_wr, time_wr, p_err;
    logic [1:0] p_err_code;
    logic [3:0] digit;

    assign is_digit = (o_rx_byte >= 8'h30) && (o_rx_byte <= 8'h39);
    assign is_cr    = (o_rx_byte == ASCII_CR);
    assign digit    = o_rx_byte[3:0];
    assign need     = (cmd == "L") ? 3'd3 : 3'd4;
    assign time_ok  = (bcd[15:12] <= 4'd2)
                   && ((bcd[15:12] == 4'd2) ? (bcd[11:8] <= 4'd3) : (bcd[11:8] <= 4'd9))
                   && (bcd[7:4] <= 4'd5) && (bcd[3:0] <= 4'd9);

`ifdef CMD_TIMEOUT_EN
    logic [TIMEOUT_BIT-1:0] to_cnt;

    assign to_hit = tick && (p_state != P_IDLE) && (to_cnt == TIMEOUT_BIT'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst || p_state == P_IDLE || o_rx_ready) to_cnt <= '0;
        else if (tick)                               to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        p_next     = p_state;
        ex_status  = 1'b0;
        ex_history = 1'b0;
        ex_change  = 1'b0;
        lev_wr     = 1'b0;
        time_wr    = 1'b0;
        p_err      = 1'b0;
        p_err_code = 2'b10;
        if (frame_bad) begin
            p_next = P_IDLE;
        end else if (o_rx_ready) begin
            case (p_state)
                P_IDLE: begin
                    if (o_rx_byte == "S" || o_rx_byte == "H" || o_rx_byte == "C") p_next = P_CR;
                    else if (o_rx_byte == "L" || o_rx_byte == "T")              p_next = P_ARGS;
                    else if (!is_cr && o_rx_byte != ASCII_LF) begin
                        p_err  = 1'b1;
                        p_next = P_FLUSH;
                    end
                end
                P_ARGS: begin
                    if (!is_digit) begin
                        p_err  = 1'b1;
                        p_next = P_FLUSH;
                    end else if (dig_cnt == need - 3'd1) begin
                        p_next = P_CR;
                    end
                end
                P_CR: begin
                    if (!is_cr) begin
                        p_err  = 1'b1;
                        p_next = P_FLUSH;
                    end else begin
                        p_next = P_IDLE;
                        case (cmd)
                            "S": ex_status  = 1'b1;
                            "H": ex_history = 1'b1;
                            "C": ex_change  = 1'b1;
                            "L": if (acc <= 10'd511) lev_wr = 1'b1;
                                 else begin p_err = 1'b1; p_err_code = 2'b11; end
                            default: if (time_ok) time_wr = 1'b1;
                                     else begin p_err = 1'b1; p_err_code = 2'b11; end
                        endcase
                    end
                end
                default: if (is_cr) p_next = P_IDLE;
            endcase
        end else if (to_hit) begin
            p_next = P_IDLE;
            if (p_state != P_FLUSH) begin
                p_err      = 1'b1;
                p_err_code = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) p_state <= P_IDLE;
        else      p_state <= p_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd     <= '0;
            dig_cnt <= '0;
            acc     <= '0;
            bcd     <= '0;
        end else if (o_rx_ready && !frame_bad) begin
            if (p_state == P_IDLE) begin
                cmd     <= o_rx_byte;
                dig_cnt <= '0;
                acc     <= '0;
                bcd     <= '0;
            end else if (p_state == P_ARGS && is_digit) begin
                dig_cnt <= dig_cnt + 1'b1;
                acc     <= acc * 10'd10 + {6'd0, digit};
                bcd     <= {bcd[11:0], digit};
            end
        end
    end

    // Registered outputs: parser strobes appear one cycle after o_rx_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_status     <= 1'b0;
            o_history    <= 1'b0;
            o_change     <= 1'b0;
            o_livello    <= 9'(LIV_DEFAULT);
            o_lev_valid  <= 1'b0;
            o_dore       <= '0;
            o_ore        <= '0;
            o_dmin       <= '0;
            o_min        <= '0;
            o_time_valid <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= 2'b00;
        end else begin
            o_status     <= ex_status;
            o_history    <= ex_history;
            o_change     <= ex_change;
            o_lev_valid  <= lev_wr;
            o_time_valid <= time_wr;
            if (lev_wr) o_livello <= acc[8:0];
            if (time_wr) {o_dore, o_ore, o_dmin, o_min} <= bcd;
            o_err <= frame_bad || p_err;
            if (frame_bad)  o_err_code <= 2'b01;
            else if (p_err) o_err_code <= p_err_code;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder; short baud divider keeps runs brief.
module tb_uart_cmd_decoder;

    localparam int BAUD = 3;
    localparam int BIT  = 16 * BAUD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic [7:0] o_rx_byte;
    logic o_rx_ready, o_status, o_history, o_change, o_lev_valid, o_time_valid, o_err;
    logic [8:0] o_livello;
    logic [3:0] o_dore, o_ore, o_dmin, o_min;
    logic [1:0] o_err_code;

    uart_cmd_decoder #(.BAUD_COUNT_x16(BAUD)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .o_rx_byte(o_rx_byte), .o_rx_ready(o_rx_ready),
        .o_status(o_status), .o_history(o_history), .o_change(o_change),
        .o_livello(o_livello), .o_lev_valid(o_lev_valid),
        .o_dore(o_dore), .o_ore(o_ore), .o_dmin(o_dmin), .o_min(o_min),
        .o_time_valid(o_time_valid), .o_err(o_err), .o_err_code(o_err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_ready, n_status, n_history, n_change, n_lev, n_time, n_err;
    int last_ready_cyc, last_cmd_cyc;
    logic [1:0] err_log [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (o_rx_ready) begin n_ready++; last_ready_cyc = cyc; end
            if (o_status)   begin n_status++;  last_cmd_cyc = cyc; end
            if (o_history)  begin n_history++; last_cmd_cyc = cyc; end
            if (o_change)   begin n_change++;  last_cmd_cyc = cyc; end
            if (o_lev_valid)  n_lev++;
            if (o_time_valid) n_time++;
            if (o_err) begin
                if (n_err < 8) err_log[n_err] = o_err_code;
                n_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_counts();
        @(posedge clk);
        n_ready = 0; n_status = 0; n_history = 0; n_change = 0;
        n_lev = 0; n_time = 0; n_err = 0;
        last_ready_cyc = -100; last_cmd_cyc = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        rx = stop;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * BIT) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        repeat (BIT) @(posedge clk);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_livello", o_livello, 100);
        check("rst_rx_byte", o_rx_byte, 0);
        check("rst_err_code", o_err_code, 0);
        check("rst_time", {o_dore, o_ore, o_dmin, o_min}, 0);
        check("rst_pulses", {o_rx_ready, o_status, o_err, o_lev_valid, o_time_valid}, 0);

        clear_counts();
        send_str("S\r");
        check("S_ready", n_ready, 2);
        check("S_status", n_status, 1);
        check("S_err", n_err, 0);
        check("S_latency", last_cmd_cyc - last_ready_cyc, 1);
        check("S_last_byte", o_rx_byte, 8'h0D);

        clear_counts();
        send_str("L250\r");
        check("L250_val", o_livello, 250);
        check("L250_valid", n_lev, 1);
        check("L250_err", n_err, 0);

        clear_counts();
        send_str("L600\r");
        check("L600_err", n_err, 1);
        check("L600_code", o_err_code, 3);
        check("L600_val", o_livello, 250);
        check("L600_valid", n_lev, 0);

        clear_counts();
        send_str("L511\r");
        check("L511_val", o_livello, 511);
        check("L511_err", n_err, 0);

        clear_counts();
        send_str("T2359\r");
        check("T2359_time", {o_dore, o_ore, o_dmin, o_min}, 16'h2359);
        check("T2359_valid", n_time, 1);

        clear_counts();
        send_str("T2400\r");
        check("T2400_err", n_err, 1);
        check("T2400_code", o_err_code, 3);
        check("T2400_time", {o_dore, o_ore, o_dmin, o_min}, 16'h2359);
        check("T2400_valid", n_time, 0);

        clear_counts();
        send_str("L250\r");
        send_str("X7\rH\r");
        check("X7_err", n_err, 1);
        check("X7_code", o_err_code, 2);
        check("X7_history", n_history, 1);

        clear_counts();
        send_str("L2A\r");
        check("L2A_err", n_err, 1);
        check("L2A_code", o_err_code, 2);
        check("L2A_val", o_livello, 250);
        check("L2A_valid", n_lev, 0);

        // Partial "L2" must be dropped by the framing error, so "C\r" executes cleanly.
        clear_counts();
        send_str("L2");
        send_byte("Q", 1'b0);
        send_str("C\r");
        check("frm_err", n_err, 1);
        check("frm_code", o_err_code, 1);
        check("frm_ready", n_ready, 4);
        check("frm_change", n_change, 1);

        clear_counts();
        rx = 1'b0;
        repeat (4 * BAUD) @(posedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        check("glitch_ready", n_ready, 0);
        check("glitch_err", n_err, 0);

        clear_counts();
        send_str("L007\r");
        check("L007_val", o_livello, 7);

        clear_counts();
        send_str("L2");
        repeat (25 * 10 * BIT) @(posedge clk);
        send_str("50\r");
`ifdef CMD_TIMEOUT_EN
        check("to_err", n_err, 2);
        check("to_code0", err_log[0], 0);
        check("to_code1", err_log[1], 2);
        check("to_val", o_livello, 7);
        check("to_valid", n_lev, 0);
`else
        check("noto_err", n_err, 0);
        check("noto_val", o_livello, 250);
        check("noto_valid", n_lev, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
